// File: rtl/round_ctrl.sv
// Round controller for the reaction game: button arbitration, randomised lights-on countdown, round outcome to the scorer.
// Define ROUND_CTRL_SYNC_EN to pass pbl/pbr through 2-flop synchronizers before use.
`timescale 1ns/1ps
module round_ctrl #(
   parameter int unsigned PRESCALE    = 1000,
   parameter int unsigned MIN_WAIT    = 16,
   parameter int unsigned LIT_TIMEOUT = 64,
   parameter int unsigned COOLDOWN    = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pbl,
   input  logic       pbr,
   input  logic [6:0] score,
   output logic       leds_on,
   output logic       winrnd,
   output logic       right
);

   localparam int unsigned T_A   = MIN_WAIT + 63;
   localparam int unsigned T_B   = (T_A > LIT_TIMEOUT) ? T_A : LIT_TIMEOUT;
   localparam int unsigned T_MAX = (T_B > COOLDOWN) ? T_B : COOLDOWN;
   localparam int unsigned TW    = $clog2(T_MAX + 1);
   localparam int unsigned PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
   localparam logic [6:0] WON_L = 7'b1110000;
   localparam logic [6:0] WON_R = 7'b0000111;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_LIT, S_HIT, S_COOL, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic          pl, pr;
   logic [7:0]    lfsr;
   logic [5:0]    w_lat;
   logic [PW-1:0] presc;
   logic [TW-1:0] tcnt;
   logic [TW:0]   tcnt_inc;
   logic          tick;
   logic          wait_done, lit_done, cool_done;
   logic          tie;
   logic          leds_d, winrnd_d, right_d, tie_d;

`ifdef ROUND_CTRL_SYNC_EN
   logic [1:0] l_sync, r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         l_sync <= '0;
         r_sync <= '0;
      end else begin
         l_sync <= {l_sync[0], pbl};
         r_sync <= {r_sync[0], pbr};
      end
   end

   assign pl = l_sync[1];
   assign pr = r_sync[1];
`else
   assign pl = pbl;
   assign pr = pbr;
`endif

   // x^8+x^6+x^5+x^4+1, free-running in every state
   always_ff @(posedge clk) begin
      if (rst) lfsr <= 8'h01;
      else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   always_ff @(posedge clk) begin
      if (rst)
         w_lat <= '0;
      else if (state_nxt == S_WAIT && state != S_WAIT)
         w_lat <= lfsr[5:0];
   end

   assign tick     = (presc == PS_LAST);
   assign tcnt_inc = {1'b0, tcnt} + (TW+1)'(1);

   // "Reaching" a count means the tick that would make the counter equal the target,
   // so the transition lands exactly PRESCALE*target cycles after state entry.
   assign wait_done = tick && (tcnt_inc >= (TW+1)'(MIN_WAIT) + (TW+1)'(w_lat));
   assign lit_done  = tick && (tcnt_inc >= (TW+1)'(LIT_TIMEOUT));
   assign cool_done = tick && (tcnt_inc >= (TW+1)'(COOLDOWN));

   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         tcnt  <= '0;
      end else if (state_nxt != state) begin
         presc <= '0;
         tcnt  <= '0;
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         if (tick && tcnt != '1)
            tcnt <= tcnt + TW'(1);
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         leds_on <= 1'b0;
         winrnd  <= 1'b0;
         right   <= 1'b0;
         tie     <= 1'b0;
      end else begin
         state   <= state_nxt;
         leds_on <= leds_d;
         winrnd  <= winrnd_d;
         right   <= right_d;
         tie     <= tie_d;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (!pl && !pr) state_nxt = S_WAIT;
         S_WAIT: begin
            if (pl || pr)       state_nxt = S_HIT;
            else if (wait_done) state_nxt = S_LIT;
         end
         S_LIT: begin
            if (pl || pr)      state_nxt = S_HIT;
            else if (lit_done) state_nxt = S_COOL;
         end
         S_HIT:  state_nxt = S_COOL;
         S_COOL: begin
            if (cool_done)
               state_nxt = (score == WON_L || score == WON_R) ? S_DONE : S_IDLE;
         end
         S_DONE: state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are computed from the next state so they are registered alongside it
   always_comb begin
      winrnd_d = (state_nxt == S_HIT);
      right_d  = winrnd_d && pr && (!pl || tie);
      tie_d    = tie ^ (winrnd_d && pl && pr);
      leds_d   = (state_nxt == S_LIT) || (state_nxt == S_HIT && state == S_LIT);
   end

endmodule
